// File: rtl/d2b_round_if.sv
// Bus between the decimal-to-binary round sequencer and its surroundings:
// debounced buttons/switches, random number generator and display logic.
interface d2b_round_if;
    logic        start;
    logic        submit;
    logic [9:0]  answer;
    logic [9:0]  number;
    logic [3:0]  level;
    logic        num_gen;
    logic [9:0]  target;
    logic [7:0]  score;
    logic [2:0]  lives;
    logic        correct;
    logic        wrong;
    logic        playing;
    logic        game_over;
    logic        win;
    logic [15:0] time_left;

    modport master (
        output start, submit, answer, number,
        input  level, num_gen, target, score, lives, correct, wrong,
               playing, game_over, win, time_left
    );

    modport slave (
        input  start, submit, answer, number,
        output level, num_gen, target, score, lives, correct, wrong,
               playing, game_over, win, time_left
    );
endinterface

// File: rtl/d2b_round_ctrl.sv
// Round sequencer for the decimal-to-binary game: target request/latch, answer
// judgement, score/lives/level tracking. D2B_ROUND_TIMEOUT_EN enables the answer window.
module d2b_round_ctrl #(
    parameter int ROUNDS_PER_LEVEL = 5,
    parameter int LIVES            = 3,
    parameter int MAX_LEVEL        = 10,
    parameter int TIMEOUT_CYCLES   = 1000
) (
    input  logic        clk,
    input  logic        reset,
    d2b_round_if.slave  rnd
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_GEN   = 3'd1;
    localparam logic [2:0] S_LATCH = 3'd2;
    localparam logic [2:0] S_PLAY  = 3'd3;
    localparam logic [2:0] S_CHECK = 3'd4;
    localparam logic [2:0] S_OVER  = 3'd5;
    localparam logic [2:0] S_WIN   = 3'd6;

    if (ROUNDS_PER_LEVEL < 1 || ROUNDS_PER_LEVEL > 15 || LIVES < 1 || LIVES > 7 ||
        MAX_LEVEL < 1 || MAX_LEVEL > 15 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("d2b_round_ctrl: parameter out of range");
    end

    logic [2:0] state_q,   state_d;
    logic [3:0] level_q,   level_d;
    logic [9:0] target_q,  target_d;
    logic [7:0] score_q,   score_d;
    logic [2:0] lives_q,   lives_d;
    logic [3:0] round_q,   round_d;
    logic       ok_q,      ok_d;
    logic       correct_q, correct_d;
    logic       wrong_q,   wrong_d;
    logic       num_gen_q;
    logic       playing_q;
    logic       over_q;
    logic       win_q;
`ifdef D2B_ROUND_TIMEOUT_EN
    logic [15:0] time_q, time_d;
`endif

    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        target_d  = target_q;
        score_d   = score_q;
        lives_d   = lives_q;
        round_d   = round_q;
        ok_d      = ok_q;
        correct_d = 1'b0;
        wrong_d   = 1'b0;
`ifdef D2B_ROUND_TIMEOUT_EN
        time_d    = time_q;
`endif
        case (state_q)
            S_IDLE, S_OVER, S_WIN: begin
                if (rnd.start) begin
                    level_d = 4'd1;
                    score_d = '0;
                    lives_d = 3'(LIVES);
                    round_d = '0;
                    state_d = S_GEN;
                end
            end
            S_GEN: state_d = S_LATCH;
            S_LATCH: begin
                target_d = rnd.number;
`ifdef D2B_ROUND_TIMEOUT_EN
                time_d   = 16'(TIMEOUT_CYCLES);
`endif
                state_d  = S_PLAY;
            end
            S_PLAY: begin
`ifdef D2B_ROUND_TIMEOUT_EN
                time_d = time_q - 16'd1;
`endif
                // Judge on entry to CHECK so the pulse lands in CHECK; ok_q stands in
                // for the registered answer when the counters update on leaving CHECK.
                if (rnd.submit) begin
                    ok_d      = (rnd.answer == target_q);
                    correct_d = ok_d;
                    wrong_d   = !ok_d;
                    state_d   = S_CHECK;
                end
`ifdef D2B_ROUND_TIMEOUT_EN
                else if (time_q == 16'd1) begin
                    ok_d    = 1'b0;
                    wrong_d = 1'b1;
                    state_d = S_CHECK;
                end
`endif
            end
            S_CHECK: begin
                if (ok_q) begin
                    if (score_q != 8'hFF) score_d = score_q + 8'd1;
                    if (round_q == 4'(ROUNDS_PER_LEVEL - 1)) begin
                        round_d = '0;
                        if (level_q == 4'(MAX_LEVEL)) begin
                            state_d = S_WIN;
                        end else begin
                            level_d = level_q + 4'd1;
                            state_d = S_GEN;
                        end
                    end else begin
                        round_d = round_q + 4'd1;
                        state_d = S_GEN;
                    end
                end else begin
                    lives_d = lives_q - 3'd1;
                    state_d = (lives_q == 3'd1) ? S_OVER : S_GEN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            level_q   <= 4'd1;
            target_q  <= '0;
            score_q   <= '0;
            lives_q   <= 3'(LIVES);
            round_q   <= '0;
            ok_q      <= 1'b0;
            correct_q <= 1'b0;
            wrong_q   <= 1'b0;
            num_gen_q <= 1'b0;
            playing_q <= 1'b0;
            over_q    <= 1'b0;
            win_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            target_q  <= target_d;
            score_q   <= score_d;
            lives_q   <= lives_d;
            round_q   <= round_d;
            ok_q      <= ok_d;
            correct_q <= correct_d;
            wrong_q   <= wrong_d;
            num_gen_q <= (state_d == S_GEN);
            playing_q <= (state_d == S_GEN) || (state_d == S_LATCH) ||
                         (state_d == S_PLAY) || (state_d == S_CHECK);
            over_q    <= (state_d == S_OVER);
            win_q     <= (state_d == S_WIN);
        end
    end

`ifdef D2B_ROUND_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) time_q <= '0;
        else       time_q <= time_d;
    end
    assign rnd.time_left = time_q;
`else
    assign rnd.time_left = '0;
`endif

    assign rnd.level     = level_q;
    assign rnd.num_gen   = num_gen_q;
    assign rnd.target    = target_q;
    assign rnd.score     = score_q;
    assign rnd.lives     = lives_q;
    assign rnd.correct   = correct_q;
    assign rnd.wrong     = wrong_q;
    assign rnd.playing   = playing_q;
    assign rnd.game_over = over_q;
    assign rnd.win       = win_q;

endmodule

// File: tb/tb_d2b_round_ctrl.sv
// Scoreboard bench for d2b_round_ctrl: judgements and post-round counters
// are predicted at submit time and checked when the DUT pulses correct/wrong.
module tb_d2b_round_ctrl;

    localparam int TB_TIMEOUT = 20;

    typedef struct {
        bit         ok;
        logic [7:0] score;
        logic [2:0] lives;
        logic [3:0] level;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    d2b_round_if rnd ();

    d2b_round_ctrl #(
        .ROUNDS_PER_LEVEL (5),
        .LIVES            (3),
        .MAX_LEVEL        (10),
        .TIMEOUT_CYCLES   (TB_TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rnd   (rnd.slave)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb_q[$];
    int   m_score, m_lives, m_level, m_rc;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_new_game();
        m_score = 0; m_lives = 3; m_level = 1; m_rc = 0;
    endtask

    task automatic model_push(input bit ok);
        exp_t e;
        if (ok) begin
            if (m_score < 255) m_score++;
            if (m_rc == 4) begin
                m_rc = 0;
                if (m_level < 10) m_level++;
            end else begin
                m_rc++;
            end
        end else begin
            m_lives--;
        end
        e.ok = ok; e.score = 8'(m_score); e.lives = 3'(m_lives); e.level = 4'(m_level);
        sb_q.push_back(e);
    endtask

    // Scoreboard consumer: judgement on the pulse, counters one cycle later.
    always @(negedge clk) begin
        if (!reset && (rnd.correct || rnd.wrong)) begin
            exp_t e;
            if (sb_q.size() == 0) begin
                check_eq("unexpected_judge", {rnd.correct, rnd.wrong}, 2'b00);
            end else begin
                e = sb_q.pop_front();
                check_eq("judge_correct", rnd.correct, e.ok);
                check_eq("judge_wrong", rnd.wrong, !e.ok);
                @(negedge clk);
                check_eq("score", rnd.score, e.score);
                check_eq("lives", rnd.lives, e.lives);
                check_eq("level", rnd.level, e.level);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_level"}, rnd.level, 1);
        check_eq({tag, "_target"}, rnd.target, 0);
        check_eq({tag, "_score"}, rnd.score, 0);
        check_eq({tag, "_lives"}, rnd.lives, 3);
        check_eq({tag, "_time"}, rnd.time_left, 0);
        check_eq({tag, "_pulses"}, {rnd.num_gen, rnd.correct, rnd.wrong}, 3'b000);
        check_eq({tag, "_flags"}, {rnd.playing, rnd.game_over, rnd.win}, 3'b000);
    endtask

    task automatic wait_gen(output int n);
        n = 0;
        while (!rnd.num_gen && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq("num_gen_seen", rnd.num_gen, 1);
    endtask

    task automatic start_game();
        rnd.start = 1'b1;
        @(negedge clk);
        rnd.start = 1'b0;
        model_new_game();
    endtask

    // Runs GEN..PLAY then submits; disturb adds a stray submit in GEN and start in PLAY.
    task automatic play_round(input logic [9:0] num, input logic [9:0] ans,
                              input int exp_lat, input bit disturb);
        int n;
        wait_gen(n);
        check_eq("gen_latency", n, exp_lat);
        check_eq("level_at_gen", rnd.level, m_level);
        rnd.number = num;
        if (disturb) rnd.submit = 1'b1;
        @(negedge clk);
        rnd.submit = 1'b0;
        check_eq("num_gen_one_cycle", rnd.num_gen, 0);
        @(negedge clk);
        check_eq("target", rnd.target, num);
        check_eq("playing", rnd.playing, 1);
        if (disturb) begin
            rnd.start = 1'b1;
            @(negedge clk);
            rnd.start = 1'b0;
            check_eq("start_ignored_target", rnd.target, num);
            check_eq("start_ignored_state", {rnd.playing, rnd.num_gen}, 2'b10);
        end
        model_push(ans == num);
        rnd.answer = ans;
        rnd.submit = 1'b1;
        @(negedge clk);
        rnd.submit = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] v;
        int n;
        int i;
        rnd.start = 1'b0; rnd.submit = 1'b0; rnd.answer = '0; rnd.number = '0;
        reset = 1'b1;
        model_new_game();
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("idle");

        // First level, including ignored start/submit and the win path.
        start_game();
        check_eq("start_level", rnd.level, 1);
        check_eq("start_lives", rnd.lives, 3);
        check_eq("start_score", rnd.score, 0);
        play_round(10'd6, 10'd6, 0, 1'b0);
        for (int r = 1; r < 50; r++) begin
            v = 10'($urandom_range(0, 1023));
            play_round(v, v, 1, (r == 1));
        end
        @(negedge clk);
        check_eq("win_flag", {rnd.win, rnd.playing, rnd.game_over}, 3'b100);
        check_eq("win_level", rnd.level, 10);
        check_eq("win_score", rnd.score, 50);

        // Three wrong answers to game over, then restart.
        start_game();
        check_eq("restart_after_win", {rnd.level, rnd.score}, {4'd1, 8'd0});
        play_round(10'h380, 10'd3, 0, 1'b0);
        play_round(10'h380, 10'd3, 1, 1'b0);
        play_round(10'h380, 10'd3, 1, 1'b0);
        @(negedge clk);
        check_eq("over_flag", {rnd.game_over, rnd.playing, rnd.win}, 3'b100);
        rnd.submit = 1'b1;
        @(negedge clk);
        rnd.submit = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("over_hold_lives", rnd.lives, 0);
        start_game();
        check_eq("restart_level", rnd.level, 1);
        check_eq("restart_lives", rnd.lives, 3);
        play_round(10'h201, 10'h201, 0, 1'b0);
        play_round(10'h0F0, 10'h0F1, 1, 1'b0);

`ifdef D2B_ROUND_TIMEOUT_EN
        // No submit: wrong is pulsed after TB_TIMEOUT PLAY cycles.
        wait_gen(n);
        rnd.number = 10'd77;
        repeat (2) @(negedge clk);
        check_eq("time_load", rnd.time_left, TB_TIMEOUT);
        model_push(1'b0);
        i = 0;
        while (!rnd.wrong && i < 40) begin
            @(negedge clk);
            i++;
        end
        check_eq("timeout_cycle", i, TB_TIMEOUT);
        // Submit on the expiry cycle wins over the timeout.
        wait_gen(n);
        rnd.number = 10'd5;
        repeat (2) @(negedge clk);
        repeat (TB_TIMEOUT - 1) @(negedge clk);
        check_eq("time_last", rnd.time_left, 1);
        model_push(1'b1);
        rnd.answer = 10'd5;
        rnd.submit = 1'b1;
        @(negedge clk);
        rnd.submit = 1'b0;
`endif

        // Reset while in PLAY.
        wait_gen(n);
        rnd.number = 10'd99;
        repeat (2) @(negedge clk);
        check_eq("pre_reset_playing", rnd.playing, 1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_rst");
        reset = 1'b0;
        model_new_game();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("post_rst_num_gen", rnd.num_gen, 0);
        end

        check_eq("scoreboard_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/d2b_round_ctrl.md
# d2b_round_ctrl

Round sequencer for the decimal-to-binary game. It starts a game, asks the random number generator for a target via a one-cycle `num_gen` pulse, and latches the target. It then waits for the player's submitted switch answer and judges it against the target. It tracks score, lives and level, and advances the level every `ROUNDS_PER_LEVEL` correct answers. It sits between the debounced button/switch inputs, the random number generator (which it drives with `level` and `num_gen`), and the display/LED logic.

## Interface
- `ROUNDS_PER_LEVEL`, 5 — correct answers needed to advance one level (1..15).
- `LIVES`, 3 — wrong answers allowed before game over (1..7).
- `MAX_LEVEL`, 10 — highest level; clearing it ends the game in WIN.
- `TIMEOUT_CYCLES`, 1000 — per-round answer window in `clk` cycles (≥2; only with `D2B_ROUND_TIMEOUT_EN`).
- `clk` in 1 — system clock.
- `reset` in 1 — reset, asynchronous, active-high; clock clk.
- `start` in 1 — one-cycle pulse; begins or restarts a game.
- `submit` in 1 — one-cycle pulse; player commits `answer`.
- `answer` in 10 — player switches, two's-complement.
- `number` in 10 — generator output, valid from the cycle after a `num_gen` pulse.
- `level` out 4 — current level, 1..`MAX_LEVEL`.
- `num_gen` out 1 — one-cycle request pulse to the generator.
- `target` out 10 — latched target for the current round.
- `score` out 8 — total correct answers, saturating at 255.
- `lives` out 3 — remaining lives.
- `correct` out 1 — one-cycle pulse on a correct judgement.
- `wrong` out 1 — one-cycle pulse on a wrong or timed-out judgement.
- `playing` out 1 — high in states GEN, LATCH, PLAY, CHECK.
- `game_over` out 1 — high in OVER.
- `win` out 1 — high in WIN.
- `time_left` out 16 — remaining answer window.

## Operation
- States: IDLE, GEN, LATCH, PLAY, CHECK, OVER, WIN.
- **Reset values:** state IDLE, `level`=1, `target`=0, `score`=0, `lives`=`LIVES`, `time_left`=0, round counter 0, all pulses 0.
- **IDLE:**
  - On `start`: load `level`=1, `score`=0, `lives`=`LIVES`, round counter 0.
  - Go to GEN.
- **GEN:** assert `num_gen` for exactly this cycle, then go to LATCH.
- **LATCH:**
  - `target` <= `number`.
  - `time_left` <= `TIMEOUT_CYCLES`.
  - Go to PLAY.
- **PLAY:**
  - `time_left` decrements by 1 per cycle.
  - On `submit`: register `answer` and go to CHECK.
  - If `time_left`==1 and no `submit`: timeout; go to CHECK with the forced result "wrong".
- **CHECK:** full 10-bit equality of the registered answer against `target`.
  - **Correct:**
    - Pulse `correct` and increment `score` (saturating).
    - If round counter == `ROUNDS_PER_LEVEL`-1: clear the round counter.
      - If `level`==`MAX_LEVEL`, go to WIN.
      - Otherwise `level`++ and go to GEN.
    - Otherwise round counter++ and go to GEN.
  - **Wrong:**
    - Pulse `wrong` and decrement `lives`.
    - If `lives` was 1, go to OVER; otherwise go to GEN (same level).
- **OVER / WIN:** hold all counters; `start` restarts exactly as from IDLE.
- **Boundary conditions:**
  - `start` in GEN, LATCH, PLAY or CHECK is ignored.
  - `submit` outside PLAY is ignored.
  - `submit` in the same cycle as timeout expiry: the submit wins.
  - `reset` in any state returns immediately to the reset values.
  - `level` only changes in CHECK, never while `num_gen` is high.

## Timing
- `start` sampled at edge N → `num_gen` high during cycle N+1.
- `target` valid from edge N+3.
- `submit` sampled at edge M → `correct`/`wrong` high during cycle M+1.
- Next `num_gen` is in cycle M+2.
- Minimum round length is 4 cycles.
- All outputs are registered; there is no combinational input-to-output path.

## Configuration
- `D2B_ROUND_TIMEOUT_EN` defined: the answer-window countdown and timeout judgement are active; `time_left` is live.
- Undefined: no timeout; PLAY waits indefinitely for `submit`; `time_left` is tied to 0 and the countdown logic is not built.

## Test plan
- **Reset then start:**
  - `num_gen` pulses exactly once, one cycle after `start`.
  - With `number`=6, `target`=6 from the third cycle.
  - `level`=1, `lives`=3, `score`=0.
- **Correct answer:** `answer`=6, `submit` → `correct` pulses, `score`=1, a new `num_gen` pulses two cycles after `submit`.
- **Level advance:**
  - After 5 correct answers, `level`=2 before the sixth `num_gen`.
  - At level 10, the 5th correct answer → `win`=1.
- **Three wrong answers** (e.g. `answer`=3 vs `target`=-128, 0x380) → `wrong` pulses each time, `lives` 2,1,0, `game_over`=1; then `start` → `level`=1, `lives`=3.
- **Timeout (macro on, `TIMEOUT_CYCLES`=20):**
  - No `submit` → `wrong` pulses at cycle 20 of PLAY.
  - `submit` on the expiry cycle is judged on `answer` instead.
- **Reset mid-PLAY** → all outputs return to reset values on the next sample, `num_gen` stays 0.
